// File: rtl/fft8_stream_ctrl_if.sv
// Stream and FFT-side signal bundle for fft8_stream_ctrl.
// The master modport is the controller's view; slave is the environment
// (upstream source, downstream sink and the FFT core).
interface fft8_stream_ctrl_if #(
  parameter int N     = 8,
  parameter int WIDTH = 12
);
  localparam int AW = $clog2(N);

  // Input sample stream
  logic                    s_valid;
  logic                    s_ready;
  logic signed [WIDTH-1:0] s_re;
  logic signed [WIDTH-1:0] s_im;

  // Output bin stream
  logic                    m_valid;
  logic                    m_ready;
  logic signed [WIDTH-1:0] m_re;
  logic signed [WIDTH-1:0] m_im;
  logic [AW-1:0]           m_index;
  logic                    m_last;

  // FFT core control and data
  logic                    fft_load;
  logic [AW-1:0]           fft_load_addr;
  logic signed [WIDTH-1:0] fft_data_re;
  logic signed [WIDTH-1:0] fft_data_im;
  logic                    fft_start;
  logic                    fft_done;
  logic [AW-1:0]           fft_out_addr;
  logic signed [WIDTH-1:0] fft_out_re;
  logic signed [WIDTH-1:0] fft_out_im;

  logic                    err;

  modport master (
    input  s_valid, s_re, s_im,
    output s_ready,
    output m_valid, m_re, m_im, m_index, m_last,
    input  m_ready,
    output fft_load, fft_load_addr, fft_data_re, fft_data_im, fft_start, fft_out_addr,
    input  fft_done, fft_out_re, fft_out_im,
    output err
  );

  modport slave (
    output s_valid, s_re, s_im,
    input  s_ready,
    input  m_valid, m_re, m_im, m_index, m_last,
    output m_ready,
    input  fft_load, fft_load_addr, fft_data_re, fft_data_im, fft_start, fft_out_addr,
    output fft_done, fft_out_re, fft_out_im,
    input  err
  );
endinterface

// File: rtl/fft8_stream_ctrl.sv
// Streaming controller around fft8_top: loads one frame of N samples at
// bit-reversed addresses, pulses start, waits for done (with timeout) and
// streams the N result bins out in natural order.
module fft8_stream_ctrl #(
  parameter int N       = 8,
  parameter int WIDTH   = 12,
  parameter int TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  fft8_stream_ctrl_if.master   bus
);

  localparam int AW  = $clog2(N);
  localparam int WCW = $clog2(TIMEOUT) + 1;
  localparam logic [AW-1:0]  LAST_IDX = AW'(N - 1);
  localparam logic [WCW-1:0] WAIT_MAX = WCW'(TIMEOUT - 1);

  typedef enum logic [1:0] {LOAD, START, WAIT, READ} state_t;

  state_t state, state_nxt;

  logic [AW-1:0]           cnt;
  logic [AW-1:0]           rd_idx;
  logic [WCW-1:0]          wait_cnt;
  logic                    vld_p1;
  logic [AW-1:0]           ld_addr_p1;
  logic signed [WIDTH-1:0] ld_re_p1;
  logic signed [WIDTH-1:0] ld_im_p1;
  logic                    start_q;
  logic [AW-1:0]           out_addr_q;
  logic                    err_q;

  logic s_ready_c, m_valid_c;
  logic accept, done_take, timeout, out_take;

  // Reverse the bit order of an AW-bit sample index.
  function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] a);
    logic [AW-1:0] r;
    for (int i = 0; i < AW; i++) r[i] = a[AW-1-i];
    return r;
  endfunction

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= LOAD;
    else     state <= state_nxt;
  end

  // Next-state and handshake decode. Done is ignored while start is still
  // high so a level done left over from the previous frame cannot be taken.
  always_comb begin
    state_nxt = state;
    s_ready_c = 1'b0;
    m_valid_c = 1'b0;
    accept    = 1'b0;
    done_take = 1'b0;
    timeout   = 1'b0;
    out_take  = 1'b0;
    case (state)
      LOAD: begin
        s_ready_c = 1'b1;
        accept    = bus.s_valid;
        if (accept && cnt == LAST_IDX) state_nxt = START;
      end
      START: state_nxt = WAIT;
      WAIT: begin
        if (!start_q && bus.fft_done) begin
          done_take = 1'b1;
          state_nxt = READ;
        end else if (wait_cnt == WAIT_MAX) begin
          timeout   = 1'b1;
          state_nxt = LOAD;
        end
      end
      READ: begin
        m_valid_c = 1'b1;
        out_take  = bus.m_ready;
        if (out_take && rd_idx == LAST_IDX) state_nxt = LOAD;
      end
      default: state_nxt = LOAD;
    endcase
  end

  // Counters, FFT write port stage, start pulse, read address and error flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      rd_idx     <= '0;
      wait_cnt   <= '0;
      vld_p1     <= 1'b0;
      ld_addr_p1 <= '0;
      ld_re_p1   <= '0;
      ld_im_p1   <= '0;
      start_q    <= 1'b0;
      out_addr_q <= '0;
      err_q      <= 1'b0;
    end else begin
      // ---- stage p1: register-file write one cycle after accept ----
      vld_p1 <= accept;
      if (accept) begin
        ld_addr_p1 <= bitrev(cnt);
        ld_re_p1   <= bus.s_re;
        ld_im_p1   <= bus.s_im;
        cnt        <= (cnt == LAST_IDX) ? '0 : cnt + 1'b1;
      end

      start_q <= (state == START);

      if (state == START) wait_cnt <= '0;
      else if (state == WAIT && !done_take && !timeout) wait_cnt <= wait_cnt + 1'b1;

      if (timeout) err_q <= 1'b1;

      if (done_take) begin
        rd_idx     <= '0;
        out_addr_q <= '0;
      end else if (out_take) begin
        if (rd_idx == LAST_IDX) begin
          rd_idx     <= '0;
          out_addr_q <= '0;
        end else begin
          rd_idx     <= rd_idx + 1'b1;
          out_addr_q <= rd_idx + 1'b1;
        end
      end
    end
  end

  assign bus.s_ready       = s_ready_c & ~rst;
  assign bus.m_valid       = m_valid_c & ~rst;
  assign bus.m_re          = bus.fft_out_re;
  assign bus.m_im          = bus.fft_out_im;
  assign bus.m_index       = rd_idx;
  assign bus.m_last        = (rd_idx == LAST_IDX);
  assign bus.fft_load      = vld_p1;
  assign bus.fft_load_addr = ld_addr_p1;
  assign bus.fft_data_re   = ld_re_p1;
  assign bus.fft_data_im   = ld_im_p1;
  assign bus.fft_start     = start_q;
  assign bus.fft_out_addr  = out_addr_q;
  assign bus.err           = err_q;

endmodule

// File: tb/tb_fft8_stream_ctrl.sv
// Directed bench for fft8_stream_ctrl with a behavioural FFT stand-in:
// bin k reads back as (16k, -k); done is a pulse, never, or a held level.
module tb_fft8_stream_ctrl;

  logic clk;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;
  int   dmode = 0;      // 0: pulse 5 cycles after start, 1: never, 2: level high
  int   sc    = 1000;   // cycles since fft_start was observed
  int   br[8] = '{0, 4, 2, 6, 1, 5, 3, 7};

  fft8_stream_ctrl_if #(.N(8), .WIDTH(12)) bus ();

  fft8_stream_ctrl #(.N(8), .WIDTH(12), .TIMEOUT(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // FFT result memory stand-in, combinational from the read address.
  always_comb begin
    bus.fft_out_re = 12'(16 * int'(bus.fft_out_addr));
    bus.fft_out_im = 12'(-int'(bus.fft_out_addr));
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (bus.fft_start) sc = 0;
    else if (sc < 1000) sc++;
    case (dmode)
      0:       bus.fft_done = (sc == 4);
      1:       bus.fft_done = 1'b0;
      default: bus.fft_done = 1'b1;
    endcase
  endtask

  // Stream n samples 1..n with s_valid held high; for a full frame also
  // check the start pulse on the edge after the START state.
  task automatic load_frame(input int n);
    bus.s_valid = 1'b1;
    for (int k = 0; k < n; k++) begin
      bus.s_re = 12'(k + 1);
      bus.s_im = 12'(0);
      n_vec++;
      if (bus.s_ready !== 1'b1) begin
        n_err++; $display("FAIL s_ready_load[%0d]: got %b expected 1", k, bus.s_ready);
      end
      step();
      n_vec++;
      if (bus.fft_load !== 1'b1 || bus.fft_load_addr !== 3'(br[k]) ||
          bus.fft_data_re !== 12'(k + 1) || bus.fft_data_im !== 12'(0)) begin
        n_err++;
        $display("FAIL load_write[%0d]: got load=%b addr=%0d re=%0d im=%0d expected load=1 addr=%0d re=%0d im=0",
                 k, bus.fft_load, bus.fft_load_addr, bus.fft_data_re, bus.fft_data_im, br[k], k + 1);
      end
      n_vec++;
      if (bus.fft_start !== 1'b0) begin
        n_err++; $display("FAIL start_early[%0d]: got %b expected 0", k, bus.fft_start);
      end
    end
    bus.s_valid = 1'b0;
    if (n == 8) begin
      n_vec++;
      if (bus.s_ready !== 1'b0) begin
        n_err++; $display("FAIL s_ready_start: got %b expected 0", bus.s_ready);
      end
      step();
      n_vec++;
      if (bus.fft_start !== 1'b1 || bus.fft_load !== 1'b0) begin
        n_err++; $display("FAIL start_pulse: got start=%b load=%b expected start=1 load=0",
                          bus.fft_start, bus.fft_load);
      end
    end
  endtask

  // Step until m_valid rises; n returns the number of edges taken.
  task automatic wait_m_valid(output int n);
    n = 0;
    while (bus.m_valid !== 1'b1 && n < 200) begin
      step();
      n++;
    end
    n_vec++;
    if (bus.m_valid !== 1'b1) begin
      n_err++; $display("FAIL read_entry_timeout: got m_valid=%b expected 1 within 200 cycles", bus.m_valid);
    end
  endtask

  // Drain all 8 bins, optionally with m_ready following 1,0,0,1 per cycle.
  task automatic read_out(input bit stall);
    int idx;
    int c;
    logic signed [11:0] er, ei;
    idx = 0;
    c   = 0;
    while (idx < 8 && c < 100) begin
      bus.m_ready = stall ? ((c % 4 == 0) || (c % 4 == 3)) : 1'b1;
      er = 12'(16 * idx);
      ei = 12'(-idx);
      n_vec++;
      if (bus.m_valid !== 1'b1 || bus.m_index !== 3'(idx) || bus.m_re !== er ||
          bus.m_im !== ei || bus.m_last !== (idx == 7) || bus.s_ready !== 1'b0) begin
        n_err++;
        $display("FAIL read_bin[%0d]: got v=%b idx=%0d re=%0d im=%0d last=%b s_ready=%b expected v=1 idx=%0d re=%0d im=%0d last=%b s_ready=0",
                 c, bus.m_valid, bus.m_index, bus.m_re, bus.m_im, bus.m_last, bus.s_ready,
                 idx, er, ei, (idx == 7));
      end
      step();
      if (bus.m_ready) idx++;
      c++;
    end
    bus.m_ready = 1'b0;
    n_vec++;
    if (idx !== 8 || bus.m_valid !== 1'b0 || bus.s_ready !== 1'b1) begin
      n_err++;
      $display("FAIL read_done: got handshakes=%0d m_valid=%b s_ready=%b expected 8 0 1",
               idx, bus.m_valid, bus.s_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    n_vec++;
    if (bus.s_ready !== 1'b0 || bus.m_valid !== 1'b0 || bus.fft_load !== 1'b0 ||
        bus.fft_start !== 1'b0 || bus.err !== 1'b0 || bus.fft_out_addr !== 3'd0 ||
        bus.fft_load_addr !== 3'd0 || bus.fft_data_re !== 12'd0) begin
      n_err++;
      $display("FAIL reset_state: got s_ready=%b m_valid=%b load=%b start=%b err=%b out_addr=%0d expected all 0",
               bus.s_ready, bus.m_valid, bus.fft_load, bus.fft_start, bus.err, bus.fft_out_addr);
    end
    rst = 1'b0;
    #1;
    n_vec++;
    if (bus.s_ready !== 1'b1) begin
      n_err++; $display("FAIL reset_release_ready: got %b expected 1", bus.s_ready);
    end
  endtask

  task automatic test_basic_frame();
    int n;
    dmode = 0;
    load_frame(8);
    wait_m_valid(n);
    n_vec++;
    if (n !== 5) begin
      n_err++; $display("FAIL basic_read_latency: got %0d expected 5", n);
    end
    read_out(1'b0);
    n_vec++;
    if (bus.err !== 1'b0) begin
      n_err++; $display("FAIL basic_err: got %b expected 0", bus.err);
    end
  endtask

  task automatic test_backpressure();
    int n;
    dmode = 0;
    load_frame(8);
    wait_m_valid(n);
    read_out(1'b1);
  endtask

  task automatic test_level_done();
    int n;
    dmode = 2;
    step();
    load_frame(8);
    wait_m_valid(n);
    n_vec++;
    if (n !== 2) begin
      n_err++; $display("FAIL level_done_latency: got %0d expected 2", n);
    end
    read_out(1'b0);
  endtask

  task automatic test_timeout();
    int n;
    dmode = 1;
    step();
    load_frame(8);
    for (int i = 0; i < 63; i++) step();
    n_vec++;
    if (bus.err !== 1'b0 || bus.s_ready !== 1'b0) begin
      n_err++; $display("FAIL timeout_early: got err=%b s_ready=%b expected 0 0", bus.err, bus.s_ready);
    end
    step();
    n_vec++;
    if (bus.err !== 1'b1 || bus.s_ready !== 1'b1 || bus.m_valid !== 1'b0) begin
      n_err++; $display("FAIL timeout_fire: got err=%b s_ready=%b m_valid=%b expected 1 1 0",
                        bus.err, bus.s_ready, bus.m_valid);
    end
    dmode = 0;
    load_frame(8);
    wait_m_valid(n);
    n_vec++;
    if (n !== 5) begin
      n_err++; $display("FAIL timeout_next_latency: got %0d expected 5", n);
    end
    read_out(1'b0);
    n_vec++;
    if (bus.err !== 1'b1) begin
      n_err++; $display("FAIL err_sticky: got %b expected 1", bus.err);
    end
  endtask

  task automatic test_reset_mid_frame();
    int n;
    dmode = 0;
    load_frame(5);
    rst = 1'b1;
    #1;
    n_vec++;
    if (bus.err !== 1'b0 || bus.s_ready !== 1'b0 || bus.fft_load !== 1'b0 ||
        bus.fft_load_addr !== 3'd0 || bus.fft_data_re !== 12'd0 || bus.m_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid_outputs: got err=%b s_ready=%b load=%b addr=%0d re=%0d m_valid=%b expected all 0",
               bus.err, bus.s_ready, bus.fft_load, bus.fft_load_addr, bus.fft_data_re, bus.m_valid);
    end
    step();
    rst = 1'b0;
    #1;
    n_vec++;
    if (bus.s_ready !== 1'b1) begin
      n_err++; $display("FAIL reset_mid_ready: got %b expected 1", bus.s_ready);
    end
    load_frame(8);
    wait_m_valid(n);
    n_vec++;
    if (n !== 5) begin
      n_err++; $display("FAIL reset_mid_latency: got %0d expected 5", n);
    end
    read_out(1'b0);
  endtask

  initial begin
    rst          = 1'b1;
    bus.s_valid  = 1'b0;
    bus.s_re     = '0;
    bus.s_im     = '0;
    bus.m_ready  = 1'b0;
    bus.fft_done = 1'b0;
    test_reset();
    test_basic_frame();
    test_backpressure();
    test_level_done();
    test_timeout();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fft8_stream_ctrl.md
Name: fft8_stream_ctrl

Overview:
- Streaming front/back-end controller for fft8_top. Accepts one frame of N complex samples over a valid/ready input stream and writes them into the FFT register file at bit-reversed addresses.
- Pulses start, waits for done (with timeout), then reads bins 0..N-1 out of the FFT in natural order onto a valid/ready output stream.
- Sits directly upstream and downstream of fft8_top and drives all of its load/start/out_addr ports.

Parameters:
N, 8, FFT points per frame; power of two, >=2; address width AW = $clog2(N)
WIDTH, 12, signed sample width (re and im), same as fft8_top
TIMEOUT, 64, maximum WAIT cycles before a frame is abandoned

Ports:
clk  in  1  clock, all logic rising-edge
rst  in  1  reset, asynchronous, active-high
s_valid  in  1  input sample valid
s_ready  out  1  controller can accept a sample
s_re  in  WIDTH  input sample real part, signed
s_im  in  WIDTH  input sample imaginary part, signed
m_valid  out  1  output bin valid
m_ready  in  1  downstream accepts bin
m_re  out  WIDTH  output bin real part
m_im  out  WIDTH  output bin imaginary part
m_index  out  AW  bin index of current output
m_last  out  1  high with bin N-1
fft_load  out  1  FFT register-file write enable
fft_load_addr  out  AW  FFT write address
fft_data_re  out  WIDTH  FFT write data, real
fft_data_im  out  WIDTH  FFT write data, imaginary
fft_start  out  1  one-cycle FFT start pulse
fft_done  in  1  FFT completion (pulse or level)
fft_out_addr  out  AW  FFT result read address
fft_out_re  in  WIDTH  FFT result real part, combinational from fft_out_addr
fft_out_im  in  WIDTH  FFT result imaginary part, combinational from fft_out_addr
err  out  1  sticky timeout flag

Behaviour:
- Reset (async, rst high): state=LOAD, cnt=0, rd_idx=0, wait_cnt=0. Registered outputs fft_load, fft_load_addr, fft_data_*, fft_start, fft_out_addr and err are all 0. s_ready and m_valid are held 0 while rst is high. A reset mid-frame abandons the frame; no partial output is produced.
- States: LOAD, START, WAIT, READ.
- LOAD:
  - s_ready=1, m_valid=0.
  - Accept = s_valid & s_ready on a clock edge. At the accept edge: fft_load<=1, fft_load_addr<=bitrev(cnt) over AW bits, fft_data_re/im<=s_re/s_im, cnt++. Write latency is 1 cycle.
  - At any edge without an accept, fft_load<=0.
  - At the edge accepting cnt==N-1: cnt<=0, state<=START.
- START:
  - s_ready=0.
  - At the edge: fft_load<=0, fft_start<=1, wait_cnt<=0, state<=WAIT.
  - fft_start is high exactly one cycle, beginning two edges after the last accept.
- WAIT:
  - At the edge entering the second WAIT cycle: fft_start<=0.
  - fft_done is ignored during the first WAIT cycle (while fft_start is high), which guards against a stale level done.
  - From the second cycle on, fft_done high at an edge: rd_idx<=0, fft_out_addr<=0, state<=READ.
  - Otherwise wait_cnt++. If wait_cnt reaches TIMEOUT-1 without done: err<=1 (sticky until rst), state<=LOAD, frame discarded.
  - fft_done seen in any other state is ignored.
- READ:
  - m_valid=1. m_re/m_im = fft_out_re/fft_out_im, combinational. m_index=rd_idx. m_last=(rd_idx==N-1).
  - m_re/m_im/m_index/m_last are stable while m_valid & !m_ready (backpressure holds indefinitely).
  - At an edge with m_ready: rd_idx++, fft_out_addr<=rd_idx+1.
  - At the edge with m_ready and rd_idx==N-1: rd_idx<=0, fft_out_addr<=0, state<=LOAD.
  - s_ready=0 throughout READ; the next frame is accepted from the cycle after the last output handshake.
- No arithmetic on the data path: values pass through unmodified and signed.
- Bit reversal for N=8: 0,1,2,3,4,5,6,7 -> addresses 0,4,2,6,1,5,3,7.

Test Plan:
- Reset, then stream x=1..8 (im=0) with s_valid held high -> fft_load high 8 consecutive cycles with addrs 0,4,2,6,1,5,3,7 carrying data 1..8; fft_start high one cycle, 2 edges after the 8th accept.
- Model FFT returns bin k = (16k, -k) when done arrives 5 cycles after start -> m_index 0..7 in order, m_re=0,16..112, m_last only at index 7, err=0.
- Toggle m_ready 1-0-0-1 pattern during READ -> no bin dropped or duplicated; m_re held constant during stalls; 8 handshakes total.
- fft_done never asserted -> err=1 after 64 WAIT cycles, state back to LOAD, s_ready=1; err stays 1 through the next good frame until rst.
- fft_done held high (level) from the previous frame into the next -> done is ignored in the first WAIT cycle, and READ starts no earlier than 2 cycles after fft_start.
- Assert rst after the 5th accept -> all outputs 0 immediately; after release, s_ready=1 and a full fresh 8-sample frame is required before fft_start.
